render_cmd_sequencer: RTL and testbench

RENDER_CMD_SEQUENCER -- requirements
Module: render_cmd_sequencer

---
 rtl/render_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_render_cmd_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_cmd_sequencer.sv
// render_cmd_sequencer: buffers draw commands and replays each one as a series
// of renderer register writes (texture, x, y, optional colour, plot).
// Build option: define RENDER_SEQ_FIFO_EN for a FIFO_DEPTH-entry command FIFO;
// without it a single holding register buffers one command.
module render_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_texture,
    input  logic [8:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [5:0]  cmd_color,
    input  logic        cmd_color_en,
    input  logic        cmd_bg,
    output logic [3:0]  master_address,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic        master_waitrequest,
    output logic        busy,
    output logic        done_pulse,
    output logic [15:0] cmds_done
);

`ifdef RENDER_SEQ_FIFO_EN
    localparam int unsigned BUF_DEPTH = FIFO_DEPTH;
`else
    localparam int unsigned BUF_DEPTH = 1;
`endif
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned X_MAX = 319;
    localparam int unsigned Y_MAX = 239;

    localparam logic [3:0] ADDR_TEX  = 4'd4;
    localparam logic [3:0] ADDR_X    = 4'd1;
    localparam logic [3:0] ADDR_Y    = 4'd2;
    localparam logic [3:0] ADDR_COL  = 4'd7;
    localparam logic [3:0] ADDR_PLOT = 4'd6;

    // Depth must be a power of two so the FIFO pointers wrap naturally.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [6:0] texture;
        logic [8:0] x;
        logic [7:0] y;
        logic [5:0] color;
        logic       color_en;
        logic       bg;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        W_TEX,
        W_X,
        W_Y,
        W_COL,
        W_PLOT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_fsm_active_nxt;
    cmd_t             w_in;
    cmd_t             w_head;

    logic [8:0]       r_cur_x;
    logic [7:0]       r_cur_y;
    logic [5:0]       r_cur_color;
    logic             r_cur_color_en;
    logic             r_cur_bg;

    // Incoming command with coordinates clamped to the visible area.
    always_comb begin
        w_in.texture  = cmd_texture;
        w_in.x        = (cmd_x > 9'(X_MAX)) ? 9'(X_MAX) : cmd_x;
        w_in.y        = (cmd_y > 8'(Y_MAX)) ? 8'(Y_MAX) : cmd_y;
        w_in.color    = cmd_color;
        w_in.color_en = cmd_color_en;
        w_in.bg       = cmd_bg;
    end

    assign w_push = cmd_valid & cmd_ready;
    assign w_pop  = (r_state == IDLE) && (r_count != '0);

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Whether the FSM will be outside IDLE after this edge.
    always_comb begin
        w_fsm_active_nxt = 1'b1;
        if (r_state == IDLE) begin
            w_fsm_active_nxt = w_pop;
        end else if (r_state == W_PLOT && !master_waitrequest) begin
            w_fsm_active_nxt = 1'b0;
        end
    end

    // Occupancy and the registered ready/busy status derived from it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            cmd_ready <= (w_count_nxt != CNT_W'(BUF_DEPTH));
            busy      <= w_fsm_active_nxt || (w_count_nxt != '0);
        end
    end

`ifdef RENDER_SEQ_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    cmd_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;

    assign w_head = r_mem[r_rptr];

    // FIFO pointers; reset flushes by realigning them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_in;
    end
`else
    cmd_t r_slot;

    assign w_head = r_slot;

    // Single holding register; only written while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_slot <= w_in;
    end
`endif

    // Write sequencer: one register write per state, advancing when accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
            done_pulse       <= 1'b0;
            cmds_done        <= '0;
            r_cur_x          <= '0;
            r_cur_y          <= '0;
            r_cur_color      <= '0;
            r_cur_color_en   <= 1'b0;
            r_cur_bg         <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state          <= W_TEX;
                        master_write     <= 1'b1;
                        master_address   <= ADDR_TEX;
                        master_writedata <= 32'(w_head.texture);
                        r_cur_x          <= w_head.x;
                        r_cur_y          <= w_head.y;
                        r_cur_color      <= w_head.color;
                        r_cur_color_en   <= w_head.color_en;
                        r_cur_bg         <= w_head.bg;
                    end
                end
                W_TEX: begin
                    if (!master_waitrequest) begin
                        if (r_cur_bg) begin
                            r_state          <= W_PLOT;
                            master_address   <= ADDR_PLOT;
                            master_writedata <= '0;
                        end else begin
                            r_state          <= W_X;
                            master_address   <= ADDR_X;
                            master_writedata <= 32'(r_cur_x);
                        end
                    end
                end
                W_X: begin
                    if (!master_waitrequest) begin
                        r_state          <= W_Y;
                        master_address   <= ADDR_Y;
                        master_writedata <= 32'(r_cur_y);
                    end
                end
                W_Y: begin
                    if (!master_waitrequest) begin
                        if (r_cur_color_en) begin
                            r_state          <= W_COL;
                            master_address   <= ADDR_COL;
                            master_writedata <= 32'(r_cur_color);
                        end else begin
                            r_state          <= W_PLOT;
                            master_address   <= ADDR_PLOT;
                            master_writedata <= '0;
                        end
                    end
                end
                W_COL: begin
                    if (!master_waitrequest) begin
                        r_state          <= W_PLOT;
                        master_address   <= ADDR_PLOT;
                        master_writedata <= '0;
                    end
                end
                W_PLOT: begin
                    if (!master_waitrequest) begin
                        r_state          <= IDLE;
                        master_write     <= 1'b0;
                        master_address   <= '0;
                        master_writedata <= '0;
                        done_pulse       <= 1'b1;
                        cmds_done        <= cmds_done + 16'd1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    master_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_render_cmd_sequencer.sv
// Testbench for render_cmd_sequencer: table of single commands with expected
// write sequences, plus hand-written stall, buffer-full and reset sequences.
module tb_render_cmd_sequencer;

`ifdef RENDER_SEQ_FIFO_EN
    localparam int TB_DEPTH = 4;
`else
    localparam int TB_DEPTH = 1;
`endif
    localparam int NV = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_texture;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [5:0]  cmd_color;
    logic        cmd_color_en;
    logic        cmd_bg;
    logic [3:0]  master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest;
    logic        busy;
    logic        done_pulse;
    logic [15:0] cmds_done;

    always #5 clk = ~clk;

    render_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_texture        (cmd_texture),
        .cmd_x              (cmd_x),
        .cmd_y              (cmd_y),
        .cmd_color          (cmd_color),
        .cmd_color_en       (cmd_color_en),
        .cmd_bg             (cmd_bg),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .busy               (busy),
        .done_pulse         (done_pulse),
        .cmds_done          (cmds_done)
    );

    typedef struct {
        logic [6:0]  tex;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [5:0]  col;
        logic        col_en;
        logic        bg;
        int          nw;
        logic [3:0]  ea [5];
        logic [31:0] ed [5];
    } vec_t;

    vec_t        vecs [NV];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_cmds = 0;
    logic [31:0] texq [$];
    int          n_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int i, input logic [6:0] tex, input logic [8:0] x,
                           input logic [7:0] y, input logic [5:0] col, input logic col_en,
                           input logic bg, input int nw,
                           input logic [3:0] a0, input logic [31:0] d0,
                           input logic [3:0] a1, input logic [31:0] d1,
                           input logic [3:0] a2, input logic [31:0] d2,
                           input logic [3:0] a3, input logic [31:0] d3,
                           input logic [3:0] a4, input logic [31:0] d4);
        vecs[i].tex = tex;  vecs[i].x = x;  vecs[i].y = y;
        vecs[i].col = col;  vecs[i].col_en = col_en;  vecs[i].bg = bg;
        vecs[i].nw  = nw;
        vecs[i].ea[0] = a0; vecs[i].ed[0] = d0;
        vecs[i].ea[1] = a1; vecs[i].ed[1] = d1;
        vecs[i].ea[2] = a2; vecs[i].ed[2] = d2;
        vecs[i].ea[3] = a3; vecs[i].ed[3] = d3;
        vecs[i].ea[4] = a4; vecs[i].ed[4] = d4;
    endtask

    task automatic drive_cmd(input logic [6:0] tex, input logic [8:0] x, input logic [7:0] y,
                             input logic [5:0] col, input logic col_en, input logic bg);
        cmd_texture = tex; cmd_x = x; cmd_y = y;
        cmd_color = col; cmd_color_en = col_en; cmd_bg = bg;
        cmd_valid = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-computed write sequences (address, data).
        add_vec(0, 7'h06, 9'd159, 8'd119, 6'd0,  1'b0, 1'b0, 4,
                4'd4, 32'd6,   4'd1, 32'd159, 4'd2, 32'd119, 4'd6, 32'd0,  4'd0, 32'd0);
        add_vec(1, 7'h6A, 9'd5,   8'd5,   6'd0,  1'b0, 1'b1, 2,
                4'd4, 32'h6A,  4'd6, 32'd0,   4'd0, 32'd0,   4'd0, 32'd0,  4'd0, 32'd0);
        add_vec(2, 7'h03, 9'd400, 8'd250, 6'h2A, 1'b1, 1'b0, 5,
                4'd4, 32'd3,   4'd1, 32'd319, 4'd2, 32'd239, 4'd7, 32'd42, 4'd6, 32'd0);
        add_vec(3, 7'h7F, 9'd319, 8'd239, 6'd0,  1'b0, 1'b0, 4,
                4'd4, 32'd127, 4'd1, 32'd319, 4'd2, 32'd239, 4'd6, 32'd0,  4'd0, 32'd0);
        add_vec(4, 7'h00, 9'd320, 8'd240, 6'd63, 1'b1, 1'b0, 5,
                4'd4, 32'd0,   4'd1, 32'd319, 4'd2, 32'd239, 4'd7, 32'd63, 4'd6, 32'd0);
        add_vec(5, 7'h11, 9'd300, 8'd200, 6'd9,  1'b1, 1'b1, 2,
                4'd4, 32'h11,  4'd6, 32'd0,   4'd0, 32'd0,   4'd0, 32'd0,  4'd0, 32'd0);

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_texture = '0; cmd_x = '0; cmd_y = '0;
        cmd_color = '0; cmd_color_en = 1'b0; cmd_bg = 1'b0;
        master_waitrequest = 1'b0;

        // Reset values
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_write",  32'(master_write), 32'd0);
        check("rst_addr",   32'(master_address), 32'd0);
        check("rst_data",   master_writedata, 32'd0);
        check("rst_done",   32'(done_pulse), 32'd0);
        check("rst_cmds",   32'(cmds_done), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_ready",  32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy",  32'(busy), 32'd0);
        next_cycle();

        // Table: one command each, no stalls
        for (int v = 0; v < NV; v++) begin
            drive_cmd(vecs[v].tex, vecs[v].x, vecs[v].y, vecs[v].col, vecs[v].col_en, vecs[v].bg);
            @(negedge clk);
            check($sformatf("v%0d_ready", v), 32'(cmd_ready), 32'd1);
            next_cycle();
            cmd_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_lat_nowrite", v), 32'(master_write), 32'd0);
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
            next_cycle();
            for (int k = 0; k < vecs[v].nw; k++) begin
                @(negedge clk);
                check($sformatf("v%0d_w%0d_write", v, k), 32'(master_write), 32'd1);
                check($sformatf("v%0d_w%0d_addr", v, k), 32'(master_address), 32'(vecs[v].ea[k]));
                check($sformatf("v%0d_w%0d_data", v, k), master_writedata, vecs[v].ed[k]);
                next_cycle();
            end
            exp_cmds++;
            @(negedge clk);
            check($sformatf("v%0d_end_write", v), 32'(master_write), 32'd0);
            check($sformatf("v%0d_done", v), 32'(done_pulse), 32'd1);
            check($sformatf("v%0d_cmds", v), 32'(cmds_done), 32'(exp_cmds));
            check($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
            next_cycle();
            @(negedge clk);
            check($sformatf("v%0d_done_once", v), 32'(done_pulse), 32'd0);
            next_cycle();
        end

        // Colour command with each write stalled for three cycles
        begin
            logic [3:0]  sa [5];
            logic [31:0] sd [5];
            sa[0] = 4'd4; sd[0] = 32'h15;
            sa[1] = 4'd1; sd[1] = 32'd80;
            sa[2] = 4'd2; sd[2] = 32'd100;
            sa[3] = 4'd7; sd[3] = 32'd0;
            sa[4] = 4'd6; sd[4] = 32'd0;
            master_waitrequest = 1'b1;
            drive_cmd(7'h15, 9'd80, 8'd100, 6'd0, 1'b1, 1'b0);
            next_cycle();
            cmd_valid = 1'b0;
            next_cycle();
            for (int k = 0; k < 5; k++) begin
                for (int c = 0; c < 4; c++) begin
                    master_waitrequest = (c < 3);
                    @(negedge clk);
                    check($sformatf("stall_w%0d_c%0d_write", k, c), 32'(master_write), 32'd1);
                    check($sformatf("stall_w%0d_c%0d_addr", k, c), 32'(master_address), 32'(sa[k]));
                    check($sformatf("stall_w%0d_c%0d_data", k, c), master_writedata, sd[k]);
                    next_cycle();
                end
            end
            master_waitrequest = 1'b0;
            exp_cmds++;
            @(negedge clk);
            check("stall_end_write", 32'(master_write), 32'd0);
            check("stall_done", 32'(done_pulse), 32'd1);
            check("stall_cmds", 32'(cmds_done), 32'(exp_cmds));
            next_cycle();
        end

        // Buffer fills while the renderer stalls, then drains in order
        master_waitrequest = 1'b1;
        drive_cmd(7'h40, 9'd0, 8'd0, 6'd0, 1'b0, 1'b1);
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("full_stuck_write", 32'(master_write), 32'd1);
        check("full_stuck_data", master_writedata, 32'h40);
        next_cycle();
        for (int i = 0; i < TB_DEPTH; i++) begin
            drive_cmd(7'(32'h50 + i), 9'd0, 8'd0, 6'd0, 1'b0, 1'b1);
            @(negedge clk);
            check($sformatf("full_ready_%0d", i), 32'(cmd_ready), 32'd1);
            next_cycle();
        end
        drive_cmd(7'(32'h50 + TB_DEPTH), 9'd0, 8'd0, 6'd0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("full_not_ready_%0d", c), 32'(cmd_ready), 32'd0);
            check($sformatf("full_hold_addr_%0d", c), 32'(master_address), 32'd4);
            check($sformatf("full_hold_data_%0d", c), master_writedata, 32'h40);
            check($sformatf("full_busy_%0d", c), 32'(busy), 32'd1);
            next_cycle();
        end
        cmd_valid = 1'b0;
        master_waitrequest = 1'b0;
        n_done = 0;
        texq.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (master_write && master_address == 4'd4) texq.push_back(master_writedata);
            if (done_pulse) n_done++;
            next_cycle();
        end
        exp_cmds += TB_DEPTH + 1;
        check("full_num_plots", 32'(texq.size()), 32'(TB_DEPTH + 1));
        check("full_num_done", 32'(n_done), 32'(TB_DEPTH + 1));
        check("full_cmds", 32'(cmds_done), 32'(exp_cmds));
        for (int i = 0; i <= TB_DEPTH; i++) begin
            if (i < texq.size()) begin
                check($sformatf("full_order_%0d", i), texq[i],
                      (i == 0) ? 32'h40 : 32'(32'h50 + i - 1));
            end
        end

        // Reset asserted while the y write is on the bus
        drive_cmd(7'h22, 9'd10, 8'd20, 6'd5, 1'b1, 1'b0);
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rstmid_tex_addr", 32'(master_address), 32'd4);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rstmid_y_addr", 32'(master_address), 32'd2);
        check("rstmid_y_data", master_writedata, 32'd20);
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rstmid_write", 32'(master_write), 32'd0);
        check("rstmid_addr",  32'(master_address), 32'd0);
        check("rstmid_busy",  32'(busy), 32'd0);
        check("rstmid_cmds",  32'(cmds_done), 32'd0);
        check("rstmid_ready", 32'(cmd_ready), 32'd0);
        check("rstmid_done",  32'(done_pulse), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rstmid_ready_after", 32'(cmd_ready), 32'd1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rstmid_no_resume", 32'(master_write), 32'd0);
        check("rstmid_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
